// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
//   Shared constants and width helpers for the parametrised router synchroniser.
//   Ports: none (package).
//     ROUTER_TIMEOUT_DEF  default stall timeout in cycles
//     ROUTER_MAX_CH       largest supported channel count
//     router_clog2        ceil(log2(value)), 0 for value <= 1
//     router_clog2_min1   router_clog2 clamped to at least 1 (address width)
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int ROUTER_TIMEOUT_DEF = 30;
  localparam int ROUTER_MAX_CH      = 16;

  function automatic int router_clog2(input int value);
    int width;
    width = 0;
    // Stop at bit 30: 1<<31 is negative as a signed int and would always compare below value.
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

  function automatic int router_clog2_min1(input int value);
    int width;
    width = router_clog2(value);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// -----------------------------------------------------------------------------
// router_sync_timer
//   One per-channel stall counter. Counts consecutive stalled cycles and emits a
//   one-cycle soft_reset pulse on the TIMEOUT-th consecutive stall edge, then
//   restarts counting so a continued stall re-fires every TIMEOUT cycles.
//   Ports:
//     clock       in   rising-edge clock
//     reset       in   synchronous active-high reset
//     stall       in   channel has valid data, is not being read, timeout enabled
//     soft_reset  out  registered one-cycle soft reset pulse
// -----------------------------------------------------------------------------
module router_sync_timer
  import router_pkg::*;
#(
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = ROUTER_TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic stall,
  output logic soft_reset
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  // Any break in the stall clears the count, so the counter can never pass CNT_LAST.
  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (stall) begin
      if (cnt_q == CNT_LAST) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_param.sv
// -----------------------------------------------------------------------------
// router_sync_param
//   Synchroniser between the router FSM and NUM_CH output FIFOs. Latches the
//   header destination, steers the FSM write strobe to the addressed FIFO,
//   returns that FIFO's full flag, exports per-FIFO valid flags and soft-resets
//   any FIFO whose reader stalls for TIMEOUT cycles. Headers naming a channel
//   that does not exist raise addr_err and the whole packet is dropped.
//   Ports:
//     clock          in   rising-edge clock
//     reset          in   synchronous active-high reset
//     detect_add     in   header present: latch data_in as destination
//     write_enb_reg  in   write current byte to the addressed FIFO
//     data_in        in   [ADDR_W] destination address
//     timeout_en     in   enables the stall timers (0 holds them at zero)
//     read_enb       in   [NUM_CH] per-FIFO read enable
//     empty          in   [NUM_CH] per-FIFO empty flag
//     full           in   [NUM_CH] per-FIFO full flag
//     vld_out        out  [NUM_CH] per-FIFO data valid (~empty)
//     soft_reset     out  [NUM_CH] per-FIFO soft reset pulse
//     write_enb      out  [NUM_CH] one-hot FIFO write enable
//     fifo_full      out  full flag of the addressed FIFO
//     addr_err       out  one-cycle pulse after an illegal address is latched
// -----------------------------------------------------------------------------
module router_sync_param
  import router_pkg::*;
#(
  parameter  int NUM_CH  = 3,
  parameter  int TIMEOUT = ROUTER_TIMEOUT_DEF,
  localparam int ADDR_W  = router_clog2_min1(NUM_CH),
  localparam int CNT_W   = router_clog2(TIMEOUT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              timeout_en,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err
);

  // One extra bit so NUM_CH itself is representable when NUM_CH is a power of two.
  localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_reg_q, addr_reg_d;
  logic              addr_ok_q, addr_ok_d;
  logic              addr_err_q, addr_err_d;
  logic              addr_legal;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] stall;

  assign addr_legal = ({1'b0, data_in} < NUM_CH_EXT);

  // Destination holds across packets until the next header.
  always_comb begin
    addr_reg_d = addr_reg_q;
    addr_ok_d  = addr_ok_q;
    addr_err_d = 1'b0;
    if (detect_add) begin
      addr_reg_d = data_in;
      addr_ok_d  = addr_legal;
      addr_err_d = ~addr_legal;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_reg_q <= '0;
      addr_ok_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_reg_q <= addr_reg_d;
      addr_ok_q  <= addr_ok_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Selection uses the registered address, so a header and a write in the same
  // cycle still go to the previous destination. An illegal address selects nothing,
  // which both drops the writes and keeps fifo_full low so the FSM never stalls.
  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = addr_ok_q && (addr_reg_q == ADDR_W'(i));
    end
  end

  assign write_enb = write_enb_reg ? ch_sel : '0;
  assign fifo_full = |(full & ch_sel);
  assign vld_out   = ~empty;
  assign addr_err  = addr_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    assign stall[g] = ~empty[g] & ~read_enb[g] & timeout_en;

    router_sync_timer #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .stall      (stall[g]),
      .soft_reset (soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_param.sv
// -----------------------------------------------------------------------------
// tb_router_sync_param
//   Three instances share one stimulus stream: NUM_CH=4/TIMEOUT=30, NUM_CH=3/
//   TIMEOUT=30 and NUM_CH=4/TIMEOUT=5. The driver pushes hand-computed
//   expectations tagged with the cycle they apply to; the monitor compares every
//   expectation due in the current cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_router_sync_param;

  localparam int S_WEN4  = 0;
  localparam int S_FULL4 = 1;
  localparam int S_ERR4  = 2;
  localparam int S_SR4   = 3;
  localparam int S_WEN3  = 4;
  localparam int S_FULL3 = 5;
  localparam int S_ERR3  = 6;
  localparam int S_SR5   = 7;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc_cnt = 0;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic       write_enb_reg;
  logic [1:0] data_in;
  logic       timeout_en;
  logic [3:0] read_enb;
  logic [3:0] empty;
  logic [3:0] full;

  logic [3:0] vld4, sr4, wen4;
  logic       full4, err4;
  logic [2:0] vld3, sr3, wen3;
  logic       full3, err3;
  logic [3:0] vld5, sr5, wen5;
  logic       full5, err5;

  router_sync_param #(.NUM_CH(4), .TIMEOUT(30)) dut4 (
    .clock(clock), .reset(reset), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
    .data_in(data_in), .timeout_en(timeout_en), .read_enb(read_enb), .empty(empty),
    .full(full), .vld_out(vld4), .soft_reset(sr4), .write_enb(wen4),
    .fifo_full(full4), .addr_err(err4)
  );

  router_sync_param #(.NUM_CH(3), .TIMEOUT(30)) dut3 (
    .clock(clock), .reset(reset), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
    .data_in(data_in), .timeout_en(timeout_en), .read_enb(read_enb[2:0]), .empty(empty[2:0]),
    .full(full[2:0]), .vld_out(vld3), .soft_reset(sr3), .write_enb(wen3),
    .fifo_full(full3), .addr_err(err3)
  );

  router_sync_param #(.NUM_CH(4), .TIMEOUT(5)) dut5 (
    .clock(clock), .reset(reset), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
    .data_in(data_in), .timeout_en(timeout_en), .read_enb(read_enb), .empty(empty),
    .full(full), .vld_out(vld5), .soft_reset(sr5), .write_enb(wen5),
    .fifo_full(full5), .addr_err(err5)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt++;

  function automatic logic [3:0] actual(input int sig);
    case (sig)
      S_WEN4:  return wen4;
      S_FULL4: return {3'b000, full4};
      S_ERR4:  return {3'b000, err4};
      S_SR4:   return sr4;
      S_WEN3:  return {1'b0, wen3};
      S_FULL3: return {3'b000, full3};
      S_ERR3:  return {3'b000, err3};
      S_SR5:   return sr5;
      default: return 4'hx;
    endcase
  endfunction

  // Monitor
  always @(negedge clock) begin
    logic [3:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc_cnt) begin
        act = actual(sb[i].sig);
        n_cmp++;
        if (act !== sb[i].exp) begin
          n_mis++;
          $display("FAIL %s cyc=%0d actual=%b required=%b", sb[i].name, cyc_cnt, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input int sig, input logic [3:0] e, input int dly, input string nm);
    exp_t x;
    x.cyc  = cyc_cnt + dly;
    x.sig  = sig;
    x.exp  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic quiet();
    detect_add    = 1'b0;
    write_enb_reg = 1'b0;
    data_in       = 2'd0;
    timeout_en    = 1'b1;
    read_enb      = 4'h0;
    empty         = 4'hF;
    full          = 4'h0;
  endtask

  task automatic rand_in();
    detect_add    = 1'($urandom_range(0, 1));
    write_enb_reg = 1'($urandom_range(0, 1));
    data_in       = 2'($urandom_range(0, 3));
    timeout_en    = 1'($urandom_range(0, 1));
    read_enb      = 4'($urandom_range(0, 15));
    empty         = 4'($urandom_range(0, 15));
    full          = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int c;
    logic [3:0] oh;

    // Reset with random inputs
    reset = 1'b1;
    rand_in();
    for (int k = 0; k < 2; k++) begin
      step();
      rand_in();
      chk(S_SR4,   4'h0, 0, "rst_soft_reset");
      chk(S_ERR4,  4'h0, 0, "rst_addr_err");
      chk(S_WEN4,  4'h0, 0, "rst_write_enb");
      chk(S_FULL4, 4'h0, 0, "rst_fifo_full");
      chk(S_ERR3,  4'h0, 0, "rst_addr_err3");
    end
    step();
    reset = 1'b0;
    quiet();
    step();

    n_cmp++;
    if (vld4 !== ~empty) begin
      n_mis++;
      $display("FAIL vld4_idle actual=%b required=%b", vld4, ~empty);
    end
    n_cmp++;
    if (vld3 !== ~empty[2:0]) begin
      n_mis++;
      $display("FAIL vld3_idle actual=%b required=%b", vld3, ~empty[2:0]);
    end

    // Steering through each legal address
    for (int a = 0; a < 4; a++) begin
      oh = 4'b0001 << a;
      detect_add = 1'b1;
      data_in    = 2'(a);
      step();
      detect_add    = 1'b0;
      write_enb_reg = 1'b1;
      full          = oh;
      chk(S_WEN4,  oh,   0, "steer_wen");
      chk(S_FULL4, 4'h1, 0, "steer_full_hit");
      chk(S_ERR4,  4'h0, 0, "steer_no_err");
      step();
      full = ~oh;
      chk(S_WEN4,  oh,   0, "steer_wen_hold");
      chk(S_FULL4, 4'h0, 0, "steer_full_other");
      step();
      write_enb_reg = 1'b0;
      full          = 4'h0;
    end

    // Header and write in the same cycle: write goes to the previous address (3)
    detect_add    = 1'b1;
    data_in       = 2'd0;
    write_enb_reg = 1'b1;
    chk(S_WEN4, 4'b1000, 0, "same_cycle_old_addr");
    step();
    detect_add = 1'b0;
    chk(S_WEN4, 4'b0001, 0, "same_cycle_new_addr");
    step();
    quiet();
    step();

    // Illegal address on the 3-channel instance
    detect_add = 1'b1;
    data_in    = 2'd3;
    step();
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    full          = 4'hF;
    chk(S_ERR3,  4'h1, 0, "illegal_err_pulse");
    chk(S_WEN3,  4'h0, 0, "illegal_wen_drop");
    chk(S_FULL3, 4'h0, 0, "illegal_full_low");
    chk(S_ERR4,  4'h0, 0, "addr3_legal_on_4ch");
    step();
    chk(S_ERR3,  4'h0, 0, "illegal_err_one_cycle");
    chk(S_WEN3,  4'h0, 0, "illegal_wen_drop2");
    chk(S_FULL3, 4'h0, 0, "illegal_full_low2");
    step();
    write_enb_reg = 1'b0;
    detect_add    = 1'b1;
    data_in       = 2'd1;
    step();
    detect_add    = 1'b0;
    write_enb_reg = 1'b1;
    chk(S_WEN3,  4'b0010, 0, "legal_after_illegal");
    chk(S_ERR3,  4'h0,    0, "legal_no_err");
    chk(S_FULL3, 4'h1,    0, "legal_full");
    step();
    quiet();
    step();

    // Timeout on channel 2, re-fire every 30
    empty[2] = 1'b0;
    #1;
    n_cmp++;
    if (vld4 !== 4'b0100) begin
      n_mis++;
      $display("FAIL vld4_ch2 actual=%b required=0100", vld4);
    end
    n_cmp++;
    if (vld5 !== ~empty) begin
      n_mis++;
      $display("FAIL vld5_ch2 actual=%b required=%b", vld5, ~empty);
    end
    chk(S_SR4, 4'b0000, 29, "to_before");
    chk(S_SR4, 4'b0100, 30, "to_fire");
    chk(S_SR4, 4'b0000, 31, "to_one_cycle");
    chk(S_SR4, 4'b0000, 59, "to_before_refire");
    chk(S_SR4, 4'b0100, 60, "to_refire");
    repeat (61) step();
    quiet();
    step();

    // Read on the would-be firing cycle cancels; counting restarts
    empty[1] = 1'b0;
    #1;
    n_cmp++;
    if (vld3 !== 3'b010) begin
      n_mis++;
      $display("FAIL vld3_ch1 actual=%b required=010", vld3);
    end
    chk(S_SR4, 4'b0000, 30, "cancel_no_pulse");
    chk(S_SR4, 4'b0000, 31, "cancel_no_pulse_late");
    chk(S_SR4, 4'b0000, 59, "cancel_restart_before");
    chk(S_SR4, 4'b0010, 60, "cancel_restart_fire");
    repeat (29) step();
    read_enb[1] = 1'b1;
    step();
    read_enb[1] = 1'b0;
    repeat (31) step();
    quiet();
    step();

    // timeout_en dropped mid-count clears the counter
    empty[1] = 1'b0;
    chk(S_SR4, 4'b0000, 30, "en_drop_no_pulse");
    chk(S_SR4, 4'b0000, 45, "en_drop_before");
    chk(S_SR4, 4'b0010, 46, "en_drop_restart_fire");
    repeat (15) step();
    timeout_en = 1'b0;
    step();
    timeout_en = 1'b1;
    repeat (31) step();
    quiet();
    step();

    // Reset mid-count on channel 0
    empty[0] = 1'b0;
    c = cyc_cnt;
    chk(S_SR4, 4'b0000, 50, "rst_mid_before");
    chk(S_SR4, 4'b0001, 51, "rst_mid_fire");
    chk(S_SR5, 4'b0000, 25, "rst_mid_t5_before");
    chk(S_SR5, 4'b0001, 26, "rst_mid_t5_fire");
    repeat (20) step();
    reset = 1'b1;
    step();
    reset         = 1'b0;
    write_enb_reg = 1'b1;
    full          = 4'hF;
    chk(S_SR4,   4'h0, 0, "rst_mid_clear");
    chk(S_WEN4,  4'h0, 0, "rst_mid_addr_cleared");
    chk(S_FULL4, 4'h0, 0, "rst_mid_full_cleared");
    step();
    write_enb_reg = 1'b0;
    full          = 4'h0;
    while (cyc_cnt < c + 53) step();
    quiet();
    repeat (3) step();

    foreach (sb[i]) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s never_checked due_cyc=%0d required=%b", sb[i].name, sb[i].cyc, sb[i].exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
